// File: rtl/dmem_access_pkg.sv
// Shared CPU defines for the MEM stage: load/store type encodings, access sizes,
// data-memory FSM states and the alignment helpers used by dmem_access.
package dmem_access_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic       sign;
    logic [1:0] size;
  } LoadType;

  typedef struct packed {
    logic [1:0] size;
  } StoreType;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DISCARD
  } dmem_state_t;

  // Mask applied to addr[1:0] to force natural alignment for a given size.
  function automatic logic [1:0] align_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 2'b11;
      SIZE_H:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (addr_lo & ~align_mask(size)) != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_access_if.sv
// Data-memory request bus: one request at a time, address phase acknowledged by
// data_addr_ok, data phase by data_ok.
interface dmem_access_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_access_store_align.sv
// store_align: byte-enable generation and lane replication of store data
// according to access size and the low address bits.
module store_align
  import dmem_access_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata
);

  always_comb begin
    o_wstrb = 4'b1111;
    case (i_size)
      SIZE_B:  o_wstrb = 4'b0001 << i_addr_lo;
      SIZE_H:  o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      default: o_wstrb = 4'b1111;
    endcase
  end

  // Every lane carries the right byte so the memory only needs to honour wstrb.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign o_wdata[gi*8 +: 8] = (i_size == SIZE_B) ? i_data[7:0] :
                                (i_size == SIZE_H) ? i_data[(gi % 2)*8 +: 8] :
                                                     i_data[gi*8 +: 8];
  end

endmodule

// File: rtl/dmem_access.sv
// dmem_access: MEM-stage load/store sequencer driving a req/addr_ok/data_ok bus.
// Define MEM_ADDR_EXC_EN to flag misaligned half/word accesses instead of aligning them.
module dmem_access
  import dmem_access_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          MEM_Valid,
  input  logic          MEM_IsStore,
  input  logic [31:0]   MEM_ALUOut,
  input  logic [31:0]   MEM_StoreData,
  input  LoadType       MEM_LoadType,
  input  StoreType      MEM_StoreType,
  input  logic          MEM_Flush,
  input  logic          WB_Ready,
  output logic          MEM_Stall,
  dmem_access_if.master bus,
  output logic          WB_Valid,
  output logic [31:0]   WB_DMOut,
  output logic [31:0]   WB_ALUOut,
  output LoadType       WB_LoadType,
  output logic          MEM_AddrErr
);

  dmem_state_t r_state, w_state_next;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr, r_wdata, r_dmout, r_alu_out;
  LoadType     r_load_type;

  logic [1:0]  w_size;
  logic        w_issue_ok, w_accept, w_capture, w_stall;
  logic [31:0] w_bus_addr, w_wdata;
  logic [3:0]  w_wstrb;

  assign w_size = MEM_IsStore ? MEM_StoreType.size : MEM_LoadType.size;

`ifdef MEM_ADDR_EXC_EN
  logic r_addr_err;
  assign w_issue_ok = !is_misaligned(w_size, MEM_ALUOut[1:0]);
  assign w_bus_addr = MEM_ALUOut;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_addr_err <= 1'b0;
    else         r_addr_err <= (r_state == S_IDLE) && MEM_Valid && !MEM_Flush && !w_issue_ok;
  end
  assign MEM_AddrErr = r_addr_err;
`else
  assign w_issue_ok  = 1'b1;
  assign w_bus_addr  = {MEM_ALUOut[31:2], MEM_ALUOut[1:0] & align_mask(w_size)};
  assign MEM_AddrErr = 1'b0;
`endif

  store_align u_store_align (
    .i_size    (w_size),
    .i_addr_lo (w_bus_addr[1:0]),
    .i_data    (MEM_StoreData),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata)
  );

  assign w_accept  = (r_state == S_IDLE) && MEM_Valid && !MEM_Flush && w_issue_ok;
  // Read data is kept only for a live load; flushed or store responses never touch WB_DMOut.
  assign w_capture = !r_wr && !MEM_Flush && bus.data_data_ok &&
                     ((r_state == S_WAIT) || ((r_state == S_REQ) && bus.data_addr_ok));

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_accept;
        if (w_accept) w_state_next = S_REQ;
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (MEM_Flush) begin
          // Once the address is accepted the response still has to be drained.
          if (bus.data_addr_ok && !bus.data_data_ok) w_state_next = S_DISCARD;
          else                                       w_state_next = S_IDLE;
        end else if (bus.data_addr_ok) begin
          w_state_next = bus.data_data_ok ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (bus.data_data_ok) w_state_next = MEM_Flush ? S_IDLE : S_DONE;
        else if (MEM_Flush)   w_state_next = S_DISCARD;
      end
      S_DONE: begin
        w_stall = !WB_Ready;
        if (WB_Ready || MEM_Flush) w_state_next = S_IDLE;
      end
      S_DISCARD: begin
        w_stall = 1'b1;
        if (bus.data_data_ok) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_size      <= 2'b00;
      r_wstrb     <= 4'b0000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_dmout     <= 32'h0;
      r_alu_out   <= 32'h0;
      r_load_type <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_wr        <= MEM_IsStore;
        r_size      <= w_size;
        r_wstrb     <= MEM_IsStore ? w_wstrb : 4'b0000;
        r_addr      <= w_bus_addr;
        r_wdata     <= MEM_IsStore ? w_wdata : 32'h0;
        r_alu_out   <= MEM_ALUOut;
        r_load_type <= MEM_LoadType;
      end
      if (w_capture) r_dmout <= bus.data_rdata;
    end
  end

  // Gated by resetn so the stall drops the moment reset is applied.
  assign MEM_Stall      = resetn && w_stall;
  assign bus.data_req   = (r_state == S_REQ);
  assign bus.data_wr    = r_wr;
  assign bus.data_size  = r_size;
  assign bus.data_addr  = r_addr;
  assign bus.data_wdata = r_wdata;
  assign bus.data_wstrb = r_wstrb;
  assign WB_Valid       = (r_state == S_DONE);
  assign WB_DMOut       = r_dmout;
  assign WB_ALUOut      = r_alu_out;
  assign WB_LoadType    = r_load_type;

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed and randomized load/store transactions against a
// byte-lane reference model, including flush, discard and reset cases.
module tb_dmem_access;
  import dmem_access_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        MEM_Valid = 1'b0, MEM_IsStore = 1'b0, MEM_Flush = 1'b0, WB_Ready = 1'b0;
  logic [31:0] MEM_ALUOut = 32'h0, MEM_StoreData = 32'h0;
  LoadType     MEM_LoadType = '0;
  StoreType    MEM_StoreType = '0;
  logic        MEM_Stall, WB_Valid, MEM_AddrErr;
  logic [31:0] WB_DMOut, WB_ALUOut;
  LoadType     WB_LoadType;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_dmout = 32'h0;

  dmem_access_if bus ();

  dmem_access dut (
    .clk           (clk),
    .resetn        (resetn),
    .MEM_Valid     (MEM_Valid),
    .MEM_IsStore   (MEM_IsStore),
    .MEM_ALUOut    (MEM_ALUOut),
    .MEM_StoreData (MEM_StoreData),
    .MEM_LoadType  (MEM_LoadType),
    .MEM_StoreType (MEM_StoreType),
    .MEM_Flush     (MEM_Flush),
    .WB_Ready      (WB_Ready),
    .MEM_Stall     (MEM_Stall),
    .bus           (bus),
    .WB_Valid      (WB_Valid),
    .WB_DMOut      (WB_DMOut),
    .WB_ALUOut     (WB_ALUOut),
    .WB_LoadType   (WB_LoadType),
    .MEM_AddrErr   (MEM_AddrErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk1("rst_req", bus.data_req, 1'b0);
    chk1("rst_wr", bus.data_wr, 1'b0);
    chk("rst_wstrb", 32'(bus.data_wstrb), 32'h0);
    chk("rst_addr", bus.data_addr, 32'h0);
    chk("rst_wdata", bus.data_wdata, 32'h0);
    chk("rst_size", 32'(bus.data_size), 32'h0);
    chk1("rst_wbvalid", WB_Valid, 1'b0);
    chk("rst_dmout", WB_DMOut, 32'h0);
    chk("rst_aluout", WB_ALUOut, 32'h0);
    chk("rst_ltype", 32'(WB_LoadType), 32'h0);
    chk1("rst_addrerr", MEM_AddrErr, 1'b0);
    chk1("rst_stall", MEM_Stall, 1'b0);
  endtask

  task automatic drive_op(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] data);
    MEM_Valid     = 1'b1;
    MEM_IsStore   = st;
    MEM_ALUOut    = addr;
    MEM_StoreData = data;
    MEM_LoadType  = '{sign: sg, size: sz};
    MEM_StoreType = '{size: sz};
  endtask

  // One complete transaction: a_dly REQ cycles before addr_ok, data_ok d_dly cycles
  // after addr_ok (0 = same cycle), r_dly DONE cycles before WB_Ready (or flush if fl).
  task automatic do_op(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rd,
                       input int a_dly, input int d_dly, input int r_dly, input logic fl);
    int          bytes, off;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_strb;
    bytes  = 1 << sz;
    e_addr = addr - (addr % bytes);
    off    = int'(e_addr % 32'd4);
    for (int i = 0; i < 4; i++) begin
      e_strb[i]        = st && (i >= off) && (i < off + bytes);
      e_wdata[8*i +: 8] = data[8*(i % bytes) +: 8];
    end
    $display("op st=%0d size=%0d addr=0x%08h data=0x%08h rdata=0x%08h dly=%0d/%0d/%0d flush_done=%0d",
             st, sz, addr, data, rd, a_dly, d_dly, r_dly, fl);
    @(negedge clk);
    drive_op(st, sz, sg, addr, data);
    #1;
    chk1("accept_stall", MEM_Stall, 1'b1);
    chk1("accept_noreq", bus.data_req, 1'b0);
    for (int c = 0; c <= a_dly; c++) begin
      @(negedge clk);
      bus.data_addr_ok = (c == a_dly);
      bus.data_data_ok = (c == a_dly) && (d_dly == 0);
      bus.data_rdata   = bus.data_data_ok ? rd : $urandom;
      #1;
      chk1("req", bus.data_req, 1'b1);
      chk("req_addr", bus.data_addr, e_addr);
      chk1("req_wr", bus.data_wr, st);
      chk("req_size", 32'(bus.data_size), 32'(sz));
      chk("req_wstrb", 32'(bus.data_wstrb), 32'(e_strb));
      if (st) chk("req_wdata", bus.data_wdata, e_wdata);
      chk1("req_stall", MEM_Stall, 1'b1);
    end
    for (int c = 1; c <= d_dly; c++) begin
      @(negedge clk);
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = (c == d_dly);
      bus.data_rdata   = (c == d_dly) ? rd : $urandom;
      #1;
      chk1("wait_noreq", bus.data_req, 1'b0);
      chk1("wait_stall", MEM_Stall, 1'b1);
      chk1("wait_novalid", WB_Valid, 1'b0);
    end
    if (!st) model_dmout = rd;
    for (int c = 0; c <= r_dly; c++) begin
      @(negedge clk);
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = $urandom;
      WB_Ready  = (c == r_dly) && !fl;
      MEM_Flush = (c == r_dly) && fl;
      #1;
      chk1("done_valid", WB_Valid, 1'b1);
      chk("done_dmout", WB_DMOut, model_dmout);
      chk("done_aluout", WB_ALUOut, addr);
      chk1("done_noreq", bus.data_req, 1'b0);
      chk1("done_stall", MEM_Stall, (c != r_dly) || fl);
      if (!st) chk("done_ltype", 32'(WB_LoadType), 32'({sg, sz}));
    end
    @(negedge clk);
    MEM_Valid = 1'b0;
    WB_Ready  = 1'b0;
    MEM_Flush = 1'b0;
    #1;
    chk1("after_novalid", WB_Valid, 1'b0);
    chk1("after_stall", MEM_Stall, 1'b0);
  endtask

  initial begin
    logic        r_st;
    logic [1:0]  r_sz;
    logic [31:0] r_addr;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    #2;
    chk_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // LW 0x100: addr_ok at cycle 2, data_ok at cycle 4, WB_Ready after 3 cycles.
    do_op(1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 2, 3, 1'b0);
    do_op(1'b1, SIZE_B, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0, 1, 0, 1'b0);
    do_op(1'b1, SIZE_H, 1'b0, 32'h102, 32'h00001234, 32'h0, 1, 0, 1, 1'b0);
    do_op(1'b0, SIZE_W, 1'b0, 32'h200, 32'h0, 32'h11223344, 0, 0, 0, 1'b0);

    $display("step flush in WAIT, data_ok 3 cycles later");
    @(negedge clk);
    drive_op(1'b0, SIZE_W, 1'b0, 32'h180, 32'h0);
    @(negedge clk);
    bus.data_addr_ok = 1'b1;
    #1 chk1("fw_req", bus.data_req, 1'b1);
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    MEM_Flush = 1'b1;
    #1 chk1("fw_wait_stall", MEM_Stall, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      MEM_Flush = 1'b0;
      drive_op(1'b0, SIZE_W, 1'b0, 32'h240, 32'h0);
      bus.data_data_ok = (c == 3);
      bus.data_rdata   = 32'hBADBAD00;
      #1;
      chk1("discard_noreq", bus.data_req, 1'b0);
      chk1("discard_stall", MEM_Stall, 1'b1);
      chk1("discard_novalid", WB_Valid, 1'b0);
    end
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    MEM_Valid = 1'b0;
    #1;
    chk1("fw_idle_novalid", WB_Valid, 1'b0);
    chk1("fw_idle_stall", MEM_Stall, 1'b0);
    do_op(1'b0, SIZE_W, 1'b0, 32'h240, 32'h0, 32'h5566AA77, 0, 1, 0, 1'b0);

    $display("step flush in REQ before addr_ok");
    @(negedge clk);
    drive_op(1'b0, SIZE_W, 1'b0, 32'h300, 32'h0);
    #1 chk1("fr_accept_stall", MEM_Stall, 1'b1);
    @(negedge clk);
    MEM_Flush = 1'b1;
    #1 chk1("fr_req", bus.data_req, 1'b1);
    @(negedge clk);
    MEM_Flush = 1'b0;
    MEM_Valid = 1'b0;
    #1;
    chk1("fr_noreq", bus.data_req, 1'b0);
    chk1("fr_stall", MEM_Stall, 1'b0);
    chk1("fr_novalid", WB_Valid, 1'b0);

    // WB_Ready held low for 5 DONE cycles.
    do_op(1'b0, SIZE_H, 1'b1, 32'h20, 32'h0, 32'h0000FF80, 0, 1, 5, 1'b0);
    do_op(1'b0, SIZE_B, 1'b1, 32'h21, 32'h0, 32'h00008100, 1, 1, 0, 1'b1);

    $display("step reset asserted in WAIT");
    @(negedge clk);
    drive_op(1'b0, SIZE_W, 1'b0, 32'h400, 32'h0);
    @(negedge clk);
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    #1 chk1("rw_wait_stall", MEM_Stall, 1'b1);
    resetn = 1'b0;
    #1 chk_reset();
    model_dmout = 32'h0;
    @(negedge clk);
    resetn = 1'b1;
    MEM_Valid = 1'b0;
    #1 chk1("rw_after_stall", MEM_Stall, 1'b0);

    $display("step LW at misaligned 0x102");
`ifdef MEM_ADDR_EXC_EN
    @(negedge clk);
    drive_op(1'b0, SIZE_W, 1'b0, 32'h102, 32'h0);
    #1;
    chk1("misal_stall", MEM_Stall, 1'b0);
    chk1("misal_noreq", bus.data_req, 1'b0);
    @(negedge clk);
    MEM_Valid = 1'b0;
    #1;
    chk1("misal_addrerr", MEM_AddrErr, 1'b1);
    chk1("misal_noreq2", bus.data_req, 1'b0);
    @(negedge clk);
    #1 chk1("misal_addrerr_pulse", MEM_AddrErr, 1'b0);
`else
    do_op(1'b0, SIZE_W, 1'b0, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1, 0, 1'b0);
    chk1("misal_addrerr_tied", MEM_AddrErr, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      r_st   = ($urandom % 2) == 1;
      r_sz   = 2'($urandom_range(0, 2));
      r_addr = $urandom;
`ifdef MEM_ADDR_EXC_EN
      r_addr = r_addr & ~((32'd1 << r_sz) - 32'd1);
`endif
      do_op(r_st, r_sz, ($urandom % 2) == 1, r_addr, $urandom, $urandom,
            $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
            ($urandom % 6) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
